// File: rtl/node_sink.sv
// node_sink: ejection endpoint on a router's local output port.
// Buffers data packets in a small FIFO, consumes ant packets on arrival,
// drains the FIFO at a rate set by i_drain_en, and keeps packet, misroute
// and latency statistics for mesh-level benches.

package node_pkg;
  localparam int COORD_W = 4;
  localparam int TS_W    = 16;

  typedef struct packed {
    logic               ant;
    logic               measure;
    logic [COORD_W-1:0] x_dest;
    logic [COORD_W-1:0] y_dest;
    logic [TS_W-1:0]    timestamp;
    logic [15:0]        payload;
  } packet_t;
endpackage

module node_sink
  import node_pkg::*;
#(
  parameter int X_LOC       = 0,
  parameter int Y_LOC       = 0,
  parameter int QUEUE_DEPTH = 4,
  // Must match node_pkg::TS_W, the timestamp width carried in packet_t.
  parameter int TIME_W      = node_pkg::TS_W
) (
  input  logic              clk,
  input  logic              reset,
  input  packet_t           i_data,
  input  logic              i_data_val,
  output logic              o_en,
  input  logic              i_drain_en,
  input  logic [TIME_W-1:0] i_time,
  output packet_t           o_pkt,
  output logic              o_pkt_val,
  output logic [31:0]       o_rx_count,
  output logic [31:0]       o_ant_count,
  output logic [31:0]       o_misroute_count,
  output logic [47:0]       o_lat_sum,
  output logic [TIME_W-1:0] o_lat_max,
  output logic              o_overflow
);

  localparam int AW    = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

  localparam logic [CNT_W-1:0]   DEPTH   = CNT_W'(QUEUE_DEPTH);
  localparam logic [CNT_W-1:0]   EN_MAX  = CNT_W'(QUEUE_DEPTH - 2);
  localparam logic [COORD_W-1:0] X_HERE  = COORD_W'(X_LOC);
  localparam logic [COORD_W-1:0] Y_HERE  = COORD_W'(Y_LOC);

  packet_t           mem_q [QUEUE_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              en_q, en_d;
  packet_t           pkt_q, pkt_d;
  logic              pkt_val_q, pkt_val_d;
  logic [31:0]       rx_q, rx_d;
  logic [31:0]       ant_q, ant_d;
  logic [31:0]       mis_q, mis_d;
  logic [47:0]       lat_sum_q, lat_sum_d;
  logic [TIME_W-1:0] lat_max_q, lat_max_d;
  logic              ovf_q, ovf_d;

  logic              drain, push, data_in, ant_in, misroute;
  packet_t           head;
  logic [TIME_W-1:0] lat;

  // Event decode, all against the pre-edge occupancy.
  always_comb begin
    head     = mem_q[rd_ptr_q];
    drain    = i_drain_en && (count_q != '0);
    data_in  = i_data_val && !i_data.ant;
    ant_in   = i_data_val && i_data.ant;
    // A full FIFO still accepts when the head leaves in the same cycle.
    push     = data_in && ((count_q < DEPTH) || drain);
    misroute = i_data_val && ((i_data.x_dest != X_HERE) || (i_data.y_dest != Y_HERE));
    lat      = i_time - head.timestamp[TIME_W-1:0];
  end

  // Next-state for pointers, occupancy, outputs and statistics.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    pkt_d     = pkt_q;
    pkt_val_d = 1'b0;
    rx_d      = rx_q;
    ant_d     = ant_q;
    mis_d     = mis_q;
    lat_sum_d = lat_sum_q;
    lat_max_d = lat_max_q;
    ovf_d     = ovf_q;

    count_d = count_q + CNT_W'(push) - CNT_W'(drain);
    // Leave one skid slot for a packet already in flight when o_en drops.
    en_d    = (count_d <= EN_MAX);

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (rx_q != '1) rx_d = rx_q + 32'd1;
    end else if (data_in) begin
      ovf_d = 1'b1;
    end

    if (ant_in && (ant_q != '1)) ant_d = ant_q + 32'd1;
    if (misroute && (mis_q != '1)) mis_d = mis_q + 32'd1;

    if (drain) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      pkt_d     = head;
      pkt_val_d = 1'b1;
      if (head.measure) begin
        lat_sum_d = lat_sum_q + 48'(lat);
        if (lat > lat_max_q) lat_max_d = lat;
      end
    end
  end

  // Control and statistics registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      en_q      <= 1'b0;
      pkt_q     <= '0;
      pkt_val_q <= 1'b0;
      rx_q      <= '0;
      ant_q     <= '0;
      mis_q     <= '0;
      lat_sum_q <= '0;
      lat_max_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      en_q      <= en_d;
      pkt_q     <= pkt_d;
      pkt_val_q <= pkt_val_d;
      rx_q      <= rx_d;
      ant_q     <= ant_d;
      mis_q     <= mis_d;
      lat_sum_q <= lat_sum_d;
      lat_max_q <= lat_max_d;
      ovf_q     <= ovf_d;
    end
  end

  // FIFO storage; contents are only ever read behind the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wr_ptr_q] <= i_data;
  end

  assign o_en             = en_q;
  assign o_pkt            = pkt_q;
  assign o_pkt_val        = pkt_val_q;
  assign o_rx_count       = rx_q;
  assign o_ant_count      = ant_q;
  assign o_misroute_count = mis_q;
  assign o_lat_sum        = lat_sum_q;
  assign o_lat_max        = lat_max_q;
  assign o_overflow       = ovf_q;

endmodule

// File: tb/tb_node_sink.sv
// Bench for node_sink: directed scenarios followed by random traffic, each
// cycle checked against a queue-based reference model.

module tb_node_sink;
  import node_pkg::*;

  localparam int QD = 4;
  localparam int TW = 16;
  localparam int XL = 2;
  localparam int YL = 1;

  logic          clk = 1'b0;
  logic          reset;
  packet_t       i_data;
  logic          i_data_val;
  logic          o_en;
  logic          i_drain_en;
  logic [TW-1:0] i_time;
  packet_t       o_pkt;
  logic          o_pkt_val;
  logic [31:0]   o_rx_count, o_ant_count, o_misroute_count;
  logic [47:0]   o_lat_sum;
  logic [TW-1:0] o_lat_max;
  logic          o_overflow;

  node_sink #(.X_LOC(XL), .Y_LOC(YL), .QUEUE_DEPTH(QD), .TIME_W(TW)) dut (
    .clk(clk), .reset(reset), .i_data(i_data), .i_data_val(i_data_val),
    .o_en(o_en), .i_drain_en(i_drain_en), .i_time(i_time), .o_pkt(o_pkt),
    .o_pkt_val(o_pkt_val), .o_rx_count(o_rx_count), .o_ant_count(o_ant_count),
    .o_misroute_count(o_misroute_count), .o_lat_sum(o_lat_sum),
    .o_lat_max(o_lat_max), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [TW-1:0] tcur = '0;
  int pulses;

  // Reference model state
  packet_t       mq[$];
  logic [31:0]   m_rx, m_ant, m_mis;
  logic [47:0]   m_sum;
  logic [TW-1:0] m_max;
  logic          m_ovf, m_en, m_val;
  packet_t       m_pkt;

  function automatic packet_t mkpkt(input logic ant, input logic meas, input int x,
                                    input int y, input logic [15:0] ts, input logic [15:0] pl);
    packet_t p;
    p.ant = ant; p.measure = meas;
    p.x_dest = 4'(x); p.y_dest = 4'(y);
    p.timestamp = ts; p.payload = pl;
    return p;
  endfunction

  function automatic logic [31:0] inc_sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_rx = 0; m_ant = 0; m_mis = 0; m_sum = 0; m_max = 0;
    m_ovf = 0; m_en = 0; m_val = 0; m_pkt = '0;
  endtask

  task automatic model_step(input logic v, input packet_t p, input logic d, input logic [TW-1:0] t);
    int pre;
    logic drn, accept;
    logic [TW-1:0] lat;
    packet_t h;
    pre = mq.size();
    drn = d && (pre > 0);
    accept = 0;
    if (v && !p.ant) begin
      if (pre < QD || drn) accept = 1;
      else m_ovf = 1;
    end
    if (v && p.ant) m_ant = inc_sat(m_ant);
    if (v && (int'(p.x_dest) != XL || int'(p.y_dest) != YL)) m_mis = inc_sat(m_mis);
    m_val = 0;
    if (drn) begin
      h = mq.pop_front();
      m_pkt = h; m_val = 1;
      if (h.measure) begin
        lat = t - h.timestamp;
        m_sum = m_sum + {32'd0, lat};
        if (lat > m_max) m_max = lat;
      end
    end
    if (accept) begin
      mq.push_back(p);
      m_rx = inc_sat(m_rx);
    end
    m_en = (mq.size() <= QD - 2);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("o_en", 64'(o_en), 64'(m_en));
    chk("o_pkt_val", 64'(o_pkt_val), 64'(m_val));
    chk("o_pkt", 64'(o_pkt), 64'(m_pkt));
    chk("o_rx_count", 64'(o_rx_count), 64'(m_rx));
    chk("o_ant_count", 64'(o_ant_count), 64'(m_ant));
    chk("o_misroute_count", 64'(o_misroute_count), 64'(m_mis));
    chk("o_lat_sum", 64'(o_lat_sum), 64'(m_sum));
    chk("o_lat_max", 64'(o_lat_max), 64'(m_max));
    chk("o_overflow", 64'(o_overflow), 64'(m_ovf));
  endtask

  task automatic cycle(input logic r, input logic v, input packet_t p, input logic d);
    reset = r; i_data_val = v; i_data = p; i_drain_en = d; i_time = tcur;
    @(posedge clk);
    if (r) model_reset();
    else model_step(v, p, d, tcur);
    #1;
    check_all();
    tcur = tcur + 1'b1;
  endtask

  task automatic idle(input int n, input logic d);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, d);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, '0, 1'b0);
      chk("o_en_in_reset", 64'(o_en), 64'd0);
    end
  endtask

  initial begin
    model_reset();
    reset = 1; i_data_val = 0; i_data = '0; i_drain_en = 0; i_time = '0;

    // Reset and idle
    do_reset();
    idle(10, 1'b0);
    chk("en_after_reset", 64'(o_en), 64'd1);

    // Three data packets, no drain
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 1'b1, mkpkt(0, 0, XL, YL, 16'h0, 16'h100 + 16'(i)), 1'b0);
    chk("rx3", 64'(o_rx_count), 64'd3);
    chk("en_low_at3", 64'(o_en), 64'd0);
    chk("no_ovf3", 64'(o_overflow), 64'd0);

    // Two more with o_en ignored: fourth fits, fifth overflows
    for (int i = 3; i < 5; i++)
      cycle(1'b0, 1'b1, mkpkt(0, 0, XL, YL, 16'h0, 16'h100 + 16'(i)), 1'b0);
    chk("rx4", 64'(o_rx_count), 64'd4);
    chk("ovf_set", 64'(o_overflow), 64'd1);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b0, '0, 1'b1);
      if (o_pkt_val) begin
        chk("drain_order", 64'(o_pkt.payload), 64'(16'h100 + 16'(pulses)));
        pulses++;
      end
    end
    chk("drain_pulses", 64'(pulses), 64'd4);
    chk("ovf_sticky", 64'(o_overflow), 64'd1);

    // Latency with timestamp wrap
    do_reset();
    idle(1, 1'b0);
    cycle(1'b0, 1'b1, mkpkt(0, 1, XL, YL, 16'hFFF0, 16'hA), 1'b0);
    tcur = 16'h0010;
    cycle(1'b0, 1'b0, '0, 1'b1);
    chk("lat_sum32", 64'(o_lat_sum), 64'd32);
    chk("lat_max20", 64'(o_lat_max), 64'h20);
    cycle(1'b0, 1'b1, mkpkt(0, 1, XL, YL, 16'h1000, 16'hB), 1'b0);
    tcur = 16'h1005;
    cycle(1'b0, 1'b0, '0, 1'b1);
    chk("lat_sum37", 64'(o_lat_sum), 64'd37);
    chk("lat_max_kept", 64'(o_lat_max), 64'h20);

    // Full FIFO with drain and arrival together
    do_reset();
    for (int i = 0; i < 4; i++)
      cycle(1'b0, 1'b1, mkpkt(0, 0, XL, YL, 16'h0, 16'h200 + 16'(i)), 1'b0);
    cycle(1'b0, 1'b1, mkpkt(0, 0, XL, YL, 16'h0, 16'h204), 1'b1);
    chk("full_swap_rx", 64'(o_rx_count), 64'd5);
    chk("full_swap_ovf", 64'(o_overflow), 64'd0);
    chk("full_swap_pkt", 64'(o_pkt.payload), 64'h200);

    // Misrouted ant into a full FIFO, then mid-stream reset
    cycle(1'b0, 1'b1, mkpkt(1, 0, XL + 1, YL, 16'h0, 16'h300), 1'b0);
    chk("ant_cnt", 64'(o_ant_count), 64'd1);
    chk("ant_mis", 64'(o_misroute_count), 64'd1);
    chk("ant_rx_same", 64'(o_rx_count), 64'd5);
    chk("ant_no_ovf", 64'(o_overflow), 64'd0);
    cycle(1'b1, 1'b1, mkpkt(0, 0, XL, YL, 16'h0, 16'h301), 1'b1);
    chk("rst_rx", 64'(o_rx_count), 64'd0);
    chk("rst_pkt", 64'(o_pkt), 64'd0);
    chk("rst_en", 64'(o_en), 64'd0);
    idle(2, 1'b1);

    // Random traffic, including occasional resets
    for (int i = 0; i < 3000; i++) begin
      logic v, d, r, a, m;
      packet_t p;
      r = ($urandom_range(0, 299) == 0);
      v = ($urandom_range(0, 99) < 60);
      d = ($urandom_range(0, 99) < 45);
      a = ($urandom_range(0, 99) < 15);
      m = $urandom_range(0, 1);
      p = mkpkt(a, m, XL + int'($urandom_range(0, 7) == 0), YL + int'($urandom_range(0, 7) == 0),
                tcur - 16'($urandom_range(0, 300)), 16'($urandom));
      if ($urandom_range(0, 31) == 0) tcur = 16'($urandom);
      cycle(r, v, p, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/node_sink.md
Name: node_sink

Overview:
- Synthesizable ejection-side endpoint that attaches to a router's local output port (port 0). It is the receiving counterpart of the per-port traffic injectors used in router benches.
- It accepts packets on the router's o_data/o_data_val and returns flow control on the router's i_en.
- It buffers data packets in a small FIFO and drains them at a controllable rate, modelling the node's consumption.
- It checks that each packet is addressed to this node, consumes ant packets, and accumulates packet, misroute and latency statistics for mesh-level testbenches.

Parameters:
- X_LOC, 0, x coordinate of this node; compared against packet x_dest.
- Y_LOC, 0, y coordinate of this node; compared against packet y_dest.
- QUEUE_DEPTH, 4, number of FIFO entries; a power of two, ≥ 2.
- TIME_W, 16, width of i_time and of the packet timestamp field; latency arithmetic is modulo 2^TIME_W.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- i_data  in  packet_t  packet from the router local output.
- i_data_val  in  1  i_data is valid this cycle.
- o_en  out  1  to router i_en; high means the router may send next cycle.
- i_drain_en  in  1  node consumes the FIFO head this cycle if the FIFO is non-empty.
- i_time  in  TIME_W  free-running cycle counter.
- o_pkt  out  packet_t  head packet as it is consumed.
- o_pkt_val  out  1  o_pkt is valid (one-cycle pulse per consumed packet).
- o_rx_count  out  32  data packets accepted into the FIFO.
- o_ant_count  out  32  ant packets consumed.
- o_misroute_count  out  32  packets (ant or data) whose x_dest/y_dest ≠ X_LOC/Y_LOC.
- o_lat_sum  out  48  sum of latencies of consumed packets with measure=1.
- o_lat_max  out  TIME_W  maximum single latency seen.
- o_overflow  out  1  sticky flag: a data packet arrived with no room and was dropped.

Behaviour:
- Reset (sync, active-high): every output is 0, including o_en and o_pkt; the FIFO is emptied (count=0, pointers=0). Reset asserted mid-operation discards FIFO contents and statistics on the next clock edge.
- Per cycle, drain and push are evaluated against the pre-edge count.
- drain = i_drain_en && count>0.
- Ant packet (i_data_val && ant=1):
  - Always consumed immediately and never enqueued, even when the FIFO is full.
  - o_ant_count increments by 1.
  - The destination check is applied.
- Data packet (i_data_val && ant=0):
  - Accepted if count<QUEUE_DEPTH, or if count==QUEUE_DEPTH and drain is set the same cycle.
  - On acceptance: written at wr_ptr and o_rx_count increments.
  - Otherwise: dropped, o_overflow is set to 1 and stays set until reset; no counter increments.
- Destination check: if x_dest≠X_LOC or y_dest≠Y_LOC, o_misroute_count increments by 1 on arrival. The packet is still accepted or consumed normally.
- Count update: count_next = count + push − drain. Simultaneous push and drain leaves count unchanged. Pointers wrap modulo QUEUE_DEPTH.
- Drain timing: on a drain, o_pkt and o_pkt_val are registered in the same edge, so the consumed packet appears one cycle after i_drain_en is sampled. When there is no drain, o_pkt_val=0 and o_pkt holds its last value.
- Latency:
  - Computed on drain for packets with measure=1: lat = (i_time − timestamp) mod 2^TIME_W, with i_time sampled in the drain cycle.
  - o_lat_sum += zero-extended lat, wrapping at 2^48.
  - o_lat_max = max(o_lat_max, lat).
  - Packets with measure=0 do not affect o_lat_sum or o_lat_max.
- Flow control:
  - o_en is registered: o_en ← (count_next ≤ QUEUE_DEPTH−2). This keeps one skid slot for a packet already launched while o_en was high.
  - The first cycle after reset deasserts shows o_en=1.
  - With a compliant router, o_overflow never sets.
- Simultaneous events:
  - An ant arriving together with a drain: both actions take effect.
  - Only one packet arrives per cycle, by construction of the interface.
- Counters saturate at all-ones; they do not wrap.
- The FIFO contents need no reset beyond the pointers; o_pkt must still read 0 until the first drain.

Test Plan:
- Reset, then 10 idle cycles → o_en=0 during reset and 1 from the first cycle after; all counters 0; o_pkt_val never high.
- QUEUE_DEPTH=4, i_drain_en=0, 3 data packets to (X_LOC,Y_LOC) on consecutive cycles → o_rx_count=3; o_en=0 from the cycle after count reaches 3; o_overflow=0.
- QUEUE_DEPTH=4, i_drain_en=0, 5 data packets with o_en ignored → o_rx_count=4, o_overflow=1. Raise i_drain_en → 4 o_pkt_val pulses in FIFO order, and o_overflow remains 1.
- Packet with measure=1, timestamp=0xFFF0, drained at i_time=0x0010 (TIME_W=16) → latency 0x20; o_lat_sum=32, o_lat_max=0x20. A later packet with latency 5 leaves o_lat_max=0x20 and makes o_lat_sum=37.
- Full FIFO (count=4) with i_drain_en=1 and a data packet arriving the same cycle → accepted; count stays 4; o_rx_count increments; no overflow.
- Ant with x_dest=X_LOC+1 while the FIFO is full → o_ant_count=1, o_misroute_count=1, o_rx_count unchanged, o_overflow=0. Assert reset mid-stream → all outputs 0 on the next edge.
